// File: rtl/fan_temp_ctrl.sv
// Fan motor PWM controller driven by the DHT11 temperature/humidity bytes.
// Auto mode picks a speed level 0-3 via a hysteresis zone FSM on temperature.
// Manual mode takes the level from manual_level. The applied level ramps
// one step per PWM period, only at the period boundary.
// Optional feature macro: HUMID_BOOST_EN (auto target bumped one level when
// humidity >= H_BOOST).
module fan_temp_ctrl #(
  parameter int unsigned PWM_PERIOD = 100_000,
  parameter int unsigned DUTY1      = 40,
  parameter int unsigned DUTY2      = 70,
  parameter int unsigned T1         = 26,
  parameter int unsigned T2         = 28,
  parameter int unsigned T3         = 30,
  parameter int unsigned HYST       = 1,
  parameter int unsigned H_BOOST    = 80
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [7:0] temperature,
  input  logic [7:0] humidity,
  input  logic       auto_en,
  input  logic [1:0] manual_level,
  output logic       fan_pwm,
  output logic [1:0] speed_level,
  output logic       period_tick
);

  localparam int unsigned CW = $clog2(PWM_PERIOD);
  localparam logic [CW-1:0] CNT_MAX = CW'(PWM_PERIOD - 1);

  // Duty thresholds in clk cycles; one extra bit so D3 can hold PWM_PERIOD.
  localparam logic [CW:0] D1 = (CW+1)'(PWM_PERIOD * DUTY1 / 100);
  localparam logic [CW:0] D2 = (CW+1)'(PWM_PERIOD * DUTY2 / 100);
  localparam logic [CW:0] D3 = (CW+1)'(PWM_PERIOD);

  localparam logic [8:0] T1_V    = 9'(T1);
  localparam logic [8:0] T2_V    = 9'(T2);
  localparam logic [8:0] T3_V    = 9'(T3);
  localparam logic [8:0] HYST_V  = 9'(HYST);
  localparam logic [8:0] BOOST_V = 9'(H_BOOST);

`ifdef HUMID_BOOST_EN
  localparam bit BoostEn = 1'b1;
`else
  localparam bit BoostEn = 1'b0;
`endif

  typedef enum logic [1:0] {Z0, Z1, Z2, Z3} zone_e;

  zone_e         zone;
  logic          run;
  logic [CW-1:0] pwm_cnt;
  logic [CW:0]   dsel;
  logic [8:0]    temp9;
  logic [8:0]    temp_hyst;
  logic          no_data;
  logic          ge1, ge2, ge3;
  logic          lt1, lt2, lt3;
  logic          boost_req;
  logic [1:0]    zone_lvl;
  logic [1:0]    auto_lvl;
  logic [1:0]    target;

  // Threshold compares, 9-bit unsigned. "temp < T - HYST" is evaluated as
  // "temp + HYST < T" so a threshold smaller than HYST never wraps.
  always_comb begin
    temp9     = {1'b0, temperature};
    temp_hyst = temp9 + HYST_V;
    no_data   = (temperature == 8'd0) && (humidity == 8'd0);
    ge1       = temp9 >= T1_V;
    ge2       = temp9 >= T2_V;
    ge3       = temp9 >= T3_V;
    lt1       = temp_hyst < T1_V;
    lt2       = temp_hyst < T2_V;
    lt3       = temp_hyst < T3_V;
  end

  // Target level selection, including the optional humidity boost.
  always_comb begin
    zone_lvl  = zone;
    boost_req = BoostEn && ({1'b0, humidity} >= BOOST_V) && (zone != Z3);
    auto_lvl  = boost_req ? zone_lvl + 2'd1 : zone_lvl;
    target    = auto_en ? auto_lvl : manual_level;
  end

  // Duty count for the currently applied level.
  always_comb begin
    dsel = '0;
    unique case (speed_level)
      2'd0: dsel = '0;
      2'd1: dsel = D1;
      2'd2: dsel = D2;
      2'd3: dsel = D3;
    endcase
  end

  // Zone FSM: at most one step per clk; missing reader data pins it to Z0.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      zone <= Z0;
    end else if (no_data) begin
      zone <= Z0;
    end else begin
      unique case (zone)
        Z0: if (ge1) zone <= Z1;
        Z1: begin
          if (ge2)      zone <= Z2;
          else if (lt1) zone <= Z0;
        end
        Z2: begin
          if (ge3)      zone <= Z3;
          else if (lt2) zone <= Z1;
        end
        Z3: if (lt3) zone <= Z2;
      endcase
    end
  end

  // PWM counter, period tick, registered PWM output and boundary ramp.
  // The first clk after reset only arms the counter, so the first tick lands
  // on the first clk and pwm_cnt==0 coincides with period_tick from then on.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      run         <= 1'b0;
      pwm_cnt     <= '0;
      period_tick <= 1'b0;
      fan_pwm     <= 1'b0;
      speed_level <= 2'd0;
    end else begin
      run     <= 1'b1;
      fan_pwm <= ({1'b0, pwm_cnt} < dsel);
      if (!run) begin
        pwm_cnt     <= '0;
        period_tick <= 1'b1;
      end else if (pwm_cnt == CNT_MAX) begin
        pwm_cnt     <= '0;
        period_tick <= 1'b1;
        if (speed_level < target)      speed_level <= speed_level + 2'd1;
        else if (speed_level > target) speed_level <= speed_level - 2'd1;
      end else begin
        pwm_cnt     <= pwm_cnt + CW'(1);
        period_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fan_temp_ctrl.sv
// Directed bench for fan_temp_ctrl with a 100-cycle PWM period.
module tb_fan_temp_ctrl;

  logic       clk = 1'b0;
  logic       reset_p;
  logic [7:0] temperature;
  logic [7:0] humidity;
  logic       auto_en;
  logic [1:0] manual_level;
  logic       fan_pwm;
  logic [1:0] speed_level;
  logic       period_tick;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef HUMID_BOOST_EN
  localparam bit Boost = 1'b1;
`else
  localparam bit Boost = 1'b0;
`endif

  fan_temp_ctrl #(.PWM_PERIOD(100)) dut (
    .clk          (clk),
    .reset_p      (reset_p),
    .temperature  (temperature),
    .humidity     (humidity),
    .auto_en      (auto_en),
    .manual_level (manual_level),
    .fan_pwm      (fan_pwm),
    .speed_level  (speed_level),
    .period_tick  (period_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Counts fan_pwm high cycles and ticks over n cycles, sampled on negedge.
  task automatic measure(input int n, output int hi, output int ticks);
    hi    = 0;
    ticks = 0;
    repeat (n) begin
      @(negedge clk);
      if (fan_pwm === 1'b1)     hi++;
      if (period_tick === 1'b1) ticks++;
    end
  endtask

  // Starting on a tick cycle, measure one full period and land on the next tick.
  task automatic period_check(input string tag, input int exp_hi, input int exp_lvl);
    int hi, tk;
    measure(100, hi, tk);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lvl"}, {30'd0, speed_level}, exp_lvl);
    check({tag, "_tick"}, tk, 1);
    check({tag, "_tick_now"}, {31'd0, period_tick}, 1);
  endtask

  initial begin
    int h1, h2, t1, t2;
    reset_p      = 1'b1;
    temperature  = 8'd0;
    humidity     = 8'd0;
    auto_en      = 1'b1;
    manual_level = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_pwm", {31'd0, fan_pwm}, 0);
    check("rst_lvl", {30'd0, speed_level}, 0);
    check("rst_tick", {31'd0, period_tick}, 0);
    reset_p = 1'b0;
    @(negedge clk);
    check("tick_first", {31'd0, period_tick}, 1);

    // No data from the reader: stays at level 0.
    period_check("nodata", 0, 0);

    // Auto ramp up to level 3.
    temperature = 8'd31;
    humidity    = 8'd50;
    period_check("ramp0", 0, 1);
    period_check("ramp1", 40, 2);
    period_check("ramp2", 70, 3);
    period_check("ramp3", 100, 3);

    // Hysteresis: settle at level 1, hold at 25, drop at 24.
    temperature = 8'd26;
    period_check("down3", 100, 2);
    period_check("down2", 70, 1);
    temperature = 8'd25;
    period_check("hyst25", 40, 1);
    temperature = 8'd24;
    period_check("hyst24", 40, 0);
    period_check("zero", 0, 0);

    // Manual mode requested mid-period: current period unaffected.
    measure(50, h1, t1);
    auto_en      = 1'b0;
    manual_level = 2'd2;
    measure(50, h2, t2);
    check("man_mid_hi", h1 + h2, 0);
    check("man_mid_tick", t1 + t2, 1);
    check("man_mid_lvl", {30'd0, speed_level}, 1);
    period_check("man1", 40, 2);
    // Lowering manual_level mid-period leaves the running duty alone.
    measure(50, h1, t1);
    check("man_half_hi", h1, 50);
    manual_level = 2'd0;
    measure(50, h2, t2);
    check("man_drop_hi", h1 + h2, 70);
    check("man_drop_lvl", {30'd0, speed_level}, 1);
    auto_en     = 1'b1;
    temperature = 8'd20;
    period_check("back1", 40, 0);
    period_check("back0", 0, 0);

    // Humidity boost (active only with the macro).
    temperature = 8'd27;
    humidity    = 8'd85;
    period_check("hum85a", 0, 1);
    period_check("hum85b", 40, Boost ? 2 : 1);
    humidity = 8'd79;
    period_check("hum79a", Boost ? 70 : 40, 1);
    period_check("hum79b", 40, 1);

    // No-data from a running level pulls it down.
    temperature = 8'd0;
    humidity    = 8'd0;
    period_check("nodata_run", 40, 0);
    temperature = 8'd27;
    humidity    = 8'd50;
    period_check("relvl", 0, 1);

    // Asynchronous reset mid-period while fan_pwm is high.
    repeat (10) @(negedge clk);
    check("pre_rst_pwm", {31'd0, fan_pwm}, 1);
    reset_p = 1'b1;
    #1;
    check("mid_rst_pwm", {31'd0, fan_pwm}, 0);
    check("mid_rst_lvl", {30'd0, speed_level}, 0);
    check("mid_rst_tick", {31'd0, period_tick}, 0);
    repeat (2) @(negedge clk);
    check("hold_rst_pwm", {31'd0, fan_pwm}, 0);
    reset_p = 1'b0;
    @(negedge clk);
    check("tick_after_rst", {31'd0, period_tick}, 1);
    period_check("post_rst", 0, 1);
    period_check("post_rst2", 40, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
